linebuf_pingpong: RTL and testbench

//  Parametrised double-buffered scanline buffer for the sprite path. The sprite engine draws line N+1

---
 rtl/linebuf_pingpong_pkg.sv | 27 ++
 rtl/linebuf_pingpong_bank.sv | 32 +++
 rtl/linebuf_pingpong.sv | 206 ++++++++++++++++++++
 tb/tb_linebuf_pingpong.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/linebuf_pingpong_pkg.sv
// Shared constants and types for the double-buffered sprite scanline buffer.
package linebuf_pingpong_pkg;

  // Default geometry: 512-pixel line, 11-bit pixel word, 4-bit colour code.
  localparam int LB_AW = 9;
  localparam int LB_DW = 11;
  localparam int LB_CW = 4;

  // Colour code that marks a pixel as see-through.
  localparam int TRANSPARENT_CODE = 0;

  // Overlap resolution between two opaque sprite pixels.
  localparam int MODE_LAST_WINS  = 0;
  localparam int MODE_FIRST_WINS = 1;

  // Top-level control states: power-on/reset clear sweep, then normal line operation.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } lb_state_e;

  // A colour code (zero-extended to 16 bits) is opaque unless it equals the transparent code.
  function automatic logic code_opaque(input logic [15:0] code);
    return code != 16'(TRANSPARENT_CODE);
  endfunction

endpackage

// File: rtl/linebuf_pingpong_bank.sv
// One scanline bank: simple dual-port RAM, one write port and one registered read port.
// Read-during-write to the same address returns the old contents.
module linebuf_bank
  import linebuf_pingpong_pkg::*;
#(
  parameter int AW = LB_AW,
  parameter int DW = LB_DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [0:DEPTH-1];

  // Storage array and read register; rdata only moves when a read is issued.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/linebuf_pingpong.sv
// Ping-pong scanline buffer for the sprite path.
// Video reads (and clears) the front bank while the sprite engine composites the next line
// into the back bank through a two-stage read-modify-write pipeline with forwarding.
module linebuf_pingpong
  import linebuf_pingpong_pkg::*;
#(
  parameter int AW   = LB_AW,
  parameter int DW   = LB_DW,
  parameter int CW   = LB_CW,
  parameter int MODE = MODE_LAST_WINS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          swap,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_adr,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_adr,
  output logic [DW-1:0] rd_dat,
  output logic          coll,
  output logic [AW-1:0] coll_adr,
  output logic          busy
);

  localparam logic [AW-1:0] ADR_LAST = '1;

  function automatic logic is_opaque(input logic [CW-1:0] px);
    return code_opaque(16'(px));
  endfunction

  // Control state
  lb_state_e     state;
  logic [AW-1:0] clr_cnt;
  logic          busy_q;
  logic          fsel;        // index of the current front bank

  // Bank port bundles, indexed by physical bank
  logic          bk_we    [2];
  logic [AW-1:0] bk_waddr [2];
  logic [DW-1:0] bk_wdata [2];
  logic          bk_re    [2];
  logic [AW-1:0] bk_raddr [2];
  logic [DW-1:0] bk_rdata [2];

  // Stage 0 (issue) signals
  logic          wr_go_p0;
  logic          rd_go_p0;
  logic          tag_p0;
  logic          fwd_p0;

  // Stage 1 (decide/commit) registers and results
  logic          vld_p1;
  logic [AW-1:0] adr_p1;
  logic [DW-1:0] dat_p1;
  logic          tag_p1;
  logic          fwd_p1;
  logic [DW-1:0] fwd_dat_p1;
  logic [DW-1:0] old_p1;
  logic [DW-1:0] res_p1;
  logic          opq_new_p1;
  logic          opq_old_p1;
  logic          store_p1;
  logic          commit_p1;
  logic          coll_p1;

  // Read path registers
  logic          rd_vld_p1;
  logic          rd_bank_p1;
  logic [DW-1:0] rd_hold;
  logic [AW-1:0] coll_adr_q;

  // Clear sweep after reset, then bank-swap tracking during normal operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      busy_q  <= 1'b1;
      fsel    <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_cnt == ADR_LAST) begin
            state  <= ST_RUN;
            busy_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (swap) begin
            fsel <= ~fsel;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  assign busy = busy_q;

  // ---- stage 0: accept requests against the current bank mapping ----
  assign wr_go_p0 = wr_en & ~busy_q & ~reset;
  assign rd_go_p0 = rd_en & ~busy_q & ~reset;
  assign tag_p0   = ~fsel;
  // The RAM read issued now cannot see the commit happening this same edge,
  // so a same-bank same-address write in stage 1 supplies the old pixel instead.
  assign fwd_p0   = vld_p1 & (adr_p1 == wr_adr) & (tag_p1 == tag_p0);

  // Stage-1 control registers; in-flight writes and reads are dropped on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      rd_vld_p1 <= 1'b0;
    end else begin
      vld_p1    <= wr_go_p0;
      rd_vld_p1 <= rd_go_p0;
    end
  end

  // Stage-1 data registers; meaningful only while the matching valid is set.
  always_ff @(posedge clk) begin
    adr_p1     <= wr_adr;
    dat_p1     <= wr_dat;
    tag_p1     <= tag_p0;
    fwd_p1     <= fwd_p0;
    fwd_dat_p1 <= res_p1;
    rd_bank_p1 <= fsel;
  end

  // ---- stage 1: transparency / priority decision and collision detect ----
  always_comb begin
    old_p1     = fwd_p1 ? fwd_dat_p1 : bk_rdata[tag_p1];
    opq_new_p1 = is_opaque(dat_p1[CW-1:0]);
    opq_old_p1 = is_opaque(old_p1[CW-1:0]);
    store_p1   = vld_p1 & opq_new_p1 & ((MODE == MODE_LAST_WINS) | ~opq_old_p1);
    commit_p1  = store_p1 & ~reset;
    coll_p1    = vld_p1 & opq_new_p1 & opq_old_p1 & ~reset;
    res_p1     = store_p1 ? dat_p1 : old_p1;
  end

  // Per-bank port steering. The sweep owns both write ports while busy.
  // A stage-1 commit is tagged with its bank, so after a swap it may land in the new
  // front bank; it outranks a read-clear there. The sprite engine does not issue a
  // write in the swap cycle, which keeps that overlap from arising in practice.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bk_we[b]    = 1'b0;
      bk_waddr[b] = rd_adr;
      bk_wdata[b] = '0;
      bk_re[b]    = 1'b0;
      bk_raddr[b] = rd_adr;
      if (busy_q) begin
        bk_we[b]    = 1'b1;
        bk_waddr[b] = clr_cnt;
      end else if (commit_p1 && (tag_p1 == 1'(b))) begin
        bk_we[b]    = 1'b1;
        bk_waddr[b] = adr_p1;
        bk_wdata[b] = dat_p1;
      end else if (rd_go_p0 && (fsel == 1'(b))) begin
        bk_we[b]    = 1'b1;
        bk_waddr[b] = rd_adr;
      end
      if (rd_go_p0 && (fsel == 1'(b))) begin
        bk_re[b]    = 1'b1;
        bk_raddr[b] = rd_adr;
      end else if (wr_go_p0 && (fsel != 1'(b))) begin
        bk_re[b]    = 1'b1;
        bk_raddr[b] = wr_adr;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    linebuf_bank #(
      .AW (AW),
      .DW (DW)
    ) u_bank (
      .clk   (clk),
      .we    (bk_we[g]),
      .waddr (bk_waddr[g]),
      .wdata (bk_wdata[g]),
      .re    (bk_re[g]),
      .raddr (bk_raddr[g]),
      .rdata (bk_rdata[g])
    );
  end

  // Output holding registers: last read pixel and last collision address.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_hold    <= '0;
      coll_adr_q <= '0;
    end else begin
      rd_hold <= rd_dat;
      if (coll_p1) begin
        coll_adr_q <= adr_p1;
      end
    end
  end

  // The front bank's read register drives rd_dat the cycle after a read; otherwise hold.
  assign rd_dat   = rd_vld_p1 ? bk_rdata[rd_bank_p1] : rd_hold;
  assign coll     = coll_p1;
  assign coll_adr = coll_p1 ? adr_p1 : coll_adr_q;

endmodule

// File: tb/tb_linebuf_pingpong.sv
// Bench for linebuf_pingpong: a MODE0 and a MODE1 instance share one stimulus stream and
// are compared against a serial array model of both banks.
module tb_linebuf_pingpong;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        swap = 1'b0;
  logic        wr_en = 1'b0;
  logic [8:0]  wr_adr = '0;
  logic [10:0] wr_dat = '0;
  logic        rd_en = 1'b0;
  logic [8:0]  rd_adr = '0;
  logic [10:0] rd_dat   [2];
  logic        coll     [2];
  logic [8:0]  coll_adr [2];
  logic        busy     [2];

  int checks = 0;
  int errors = 0;

  // Model: [mode][bank][address], front bank index, expected outputs per mode.
  logic [10:0] mdl [2][2][512];
  logic        mfsel;
  logic [10:0] exp_rd   [2];
  logic        exp_coll [2];
  logic [8:0]  exp_cadr [2];

  always #5 clk = ~clk;

  linebuf_pingpong #(.AW(9), .DW(11), .CW(4), .MODE(0)) dut0 (
    .clk(clk), .reset(reset), .swap(swap), .wr_en(wr_en), .wr_adr(wr_adr), .wr_dat(wr_dat),
    .rd_en(rd_en), .rd_adr(rd_adr), .rd_dat(rd_dat[0]), .coll(coll[0]),
    .coll_adr(coll_adr[0]), .busy(busy[0]));

  linebuf_pingpong #(.AW(9), .DW(11), .CW(4), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .swap(swap), .wr_en(wr_en), .wr_adr(wr_adr), .wr_dat(wr_dat),
    .rd_en(rd_en), .rd_adr(rd_adr), .rd_dat(rd_dat[1]), .coll(coll[1]),
    .coll_adr(coll_adr[1]), .busy(busy[1]));

  task automatic idle();
    swap = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < 512; a++) mdl[m][b][a] = '0;
      exp_rd[m] = '0; exp_coll[m] = 1'b0; exp_cadr[m] = '0;
    end
    mfsel = 1'b0;
  endtask

  // Serial effect of one cycle's requests: read-and-clear front, composite into back, then swap.
  task automatic model_step();
    logic [10:0] old;
    for (int m = 0; m < 2; m++) begin
      exp_coll[m] = 1'b0;
      if (rd_en) begin
        exp_rd[m] = mdl[m][int'(mfsel)][rd_adr];
        mdl[m][int'(mfsel)][rd_adr] = '0;
      end
      if (wr_en) begin
        old = mdl[m][int'(!mfsel)][wr_adr];
        if (wr_dat[3:0] != 4'd0) begin
          if (old[3:0] != 4'd0) begin
            exp_coll[m] = 1'b1;
            exp_cadr[m] = wr_adr;
          end
          if (m == 0 || old[3:0] == 4'd0) mdl[m][int'(!mfsel)][wr_adr] = wr_dat;
        end
      end
    end
    if (swap) mfsel = !mfsel;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; idle();
    repeat (3) cycle();
    model_clear();
    for (int m = 0; m < 2; m++) begin
      checks++; if (busy[m] !== 1'b1) begin errors++; $display("FAIL reset_busy m%0d: got %b expected 1", m, busy[m]); end
      checks++; if (rd_dat[m] !== 11'h000) begin errors++; $display("FAIL reset_rd_dat m%0d: got %h expected 000", m, rd_dat[m]); end
      checks++; if (coll[m] !== 1'b0) begin errors++; $display("FAIL reset_coll m%0d: got %b expected 0", m, coll[m]); end
      checks++; if (coll_adr[m] !== 9'h000) begin errors++; $display("FAIL reset_coll_adr m%0d: got %h expected 000", m, coll_adr[m]); end
    end
    reset = 1'b0;
    n = 0;
    // Requests during the sweep must be ignored.
    while (busy[0] === 1'b1 && n < 1000) begin
      rd_en = 1'b1; rd_adr = 9'(n);
      wr_en = 1'b1; wr_adr = 9'(n) - 9'd3; wr_dat = 11'h7FF;
      @(posedge clk); #1;
      n++;
    end
    idle();
    checks++; if (n != 512) begin errors++; $display("FAIL clear_len: got %0d cycles expected 512", n); end
    for (int m = 0; m < 2; m++) begin
      checks++; if (busy[m] !== 1'b0) begin errors++; $display("FAIL clear_done m%0d: got %b expected 0", m, busy[m]); end
      checks++; if (rd_dat[m] !== 11'h000) begin errors++; $display("FAIL clear_rd_dat m%0d: got %h expected 000", m, rd_dat[m]); end
    end
    for (int pass = 0; pass < 2; pass++) begin
      for (int a = 0; a < 512; a++) begin
        rd_en = 1'b1; rd_adr = 9'(a);
        cycle();
        for (int m = 0; m < 2; m++) begin
          checks++;
          if (rd_dat[m] !== 11'h000) begin errors++; $display("FAIL sweep_zero m%0d bank_pass%0d adr %0d: got %h expected 000", m, pass, a, rd_dat[m]); end
        end
      end
      idle(); swap = 1'b1;
      cycle();
      idle();
    end
  endtask

  task automatic test_read_clear();
    wr_en = 1'b1; wr_adr = 9'd5; wr_dat = 11'h013;
    cycle();
    idle(); swap = 1'b1;
    cycle();
    idle(); rd_en = 1'b1; rd_adr = 9'd5;
    cycle();
    for (int m = 0; m < 2; m++) begin
      checks++; if (rd_dat[m] !== 11'h013) begin errors++; $display("FAIL read_first m%0d: got %h expected 013", m, rd_dat[m]); end
    end
    idle();
    cycle();
    for (int m = 0; m < 2; m++) begin
      checks++; if (rd_dat[m] !== 11'h013) begin errors++; $display("FAIL read_hold m%0d: got %h expected 013", m, rd_dat[m]); end
    end
    rd_en = 1'b1; rd_adr = 9'd5;
    cycle();
    idle();
    for (int m = 0; m < 2; m++) begin
      checks++; if (rd_dat[m] !== 11'h000) begin errors++; $display("FAIL read_cleared m%0d: got %h expected 000", m, rd_dat[m]); end
    end
  endtask

  task automatic test_collision();
    wr_en = 1'b1; wr_adr = 9'd7; wr_dat = 11'h021;
    cycle();
    for (int m = 0; m < 2; m++) begin
      checks++; if (coll[m] !== 1'b0) begin errors++; $display("FAIL coll_first m%0d: got %b expected 0", m, coll[m]); end
    end
    wr_dat = 11'h035;
    cycle();
    idle();
    for (int m = 0; m < 2; m++) begin
      checks++; if (coll[m] !== 1'b1) begin errors++; $display("FAIL coll_second m%0d: got %b expected 1", m, coll[m]); end
      checks++; if (coll_adr[m] !== 9'd7) begin errors++; $display("FAIL coll_adr m%0d: got %0d expected 7", m, coll_adr[m]); end
    end
    cycle();
    for (int m = 0; m < 2; m++) begin
      checks++; if (coll[m] !== 1'b0) begin errors++; $display("FAIL coll_pulse m%0d: got %b expected 0", m, coll[m]); end
      checks++; if (coll_adr[m] !== 9'd7) begin errors++; $display("FAIL coll_adr_hold m%0d: got %0d expected 7", m, coll_adr[m]); end
    end
    swap = 1'b1;
    cycle();
    idle(); rd_en = 1'b1; rd_adr = 9'd7;
    cycle();
    idle();
    checks++; if (rd_dat[0] !== 11'h035) begin errors++; $display("FAIL coll_value_mode0: got %h expected 035", rd_dat[0]); end
    checks++; if (rd_dat[1] !== 11'h021) begin errors++; $display("FAIL coll_value_mode1: got %h expected 021", rd_dat[1]); end
  endtask

  task automatic test_transparent();
    wr_en = 1'b1; wr_adr = 9'd9; wr_dat = 11'h021;
    cycle();
    wr_dat = 11'h030;
    cycle();
    idle();
    for (int m = 0; m < 2; m++) begin
      checks++; if (coll[m] !== 1'b0) begin errors++; $display("FAIL transp_coll m%0d: got %b expected 0", m, coll[m]); end
    end
    swap = 1'b1;
    cycle();
    idle(); rd_en = 1'b1; rd_adr = 9'd9;
    cycle();
    idle();
    for (int m = 0; m < 2; m++) begin
      checks++; if (rd_dat[m] !== 11'h021) begin errors++; $display("FAIL transp_value m%0d: got %h expected 021", m, rd_dat[m]); end
    end
  endtask

  task automatic test_swap_pipeline();
    wr_en = 1'b1; wr_adr = 9'd3; wr_dat = 11'h05A;
    cycle();
    idle(); swap = 1'b1;
    cycle();
    idle(); rd_en = 1'b1; rd_adr = 9'd3;
    cycle();
    idle();
    for (int m = 0; m < 2; m++) begin
      checks++; if (rd_dat[m] !== 11'h05A) begin errors++; $display("FAIL swap_inflight m%0d: got %h expected 05a", m, rd_dat[m]); end
    end
  endtask

  task automatic test_random();
    logic [10:0] d;
    for (int i = 0; i < 800; i++) begin
      swap   = ($urandom_range(0, 19) == 0);
      wr_en  = !swap && ($urandom_range(0, 2) != 0);
      wr_adr = 9'($urandom_range(0, 15));
      d      = 11'($urandom);
      if ($urandom_range(0, 3) == 0) d[3:0] = 4'd0;
      wr_dat = d;
      rd_en  = ($urandom_range(0, 1) == 1);
      rd_adr = 9'($urandom_range(0, 15));
      cycle();
      for (int m = 0; m < 2; m++) begin
        checks++; if (rd_dat[m] !== exp_rd[m]) begin errors++; $display("FAIL rand_rd_dat m%0d it%0d: got %h expected %h", m, i, rd_dat[m], exp_rd[m]); end
        checks++; if (coll[m] !== exp_coll[m]) begin errors++; $display("FAIL rand_coll m%0d it%0d: got %b expected %b", m, i, coll[m], exp_coll[m]); end
        checks++; if (coll_adr[m] !== exp_cadr[m]) begin errors++; $display("FAIL rand_coll_adr m%0d it%0d: got %0d expected %0d", m, i, coll_adr[m], exp_cadr[m]); end
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    wr_en = 1'b1; wr_adr = 9'd11; wr_dat = 11'h021;
    cycle();
    wr_dat = 11'h035;
    cycle();
    checks++; if (coll[0] !== 1'b1) begin errors++; $display("FAIL midreset_pending: got %b expected 1", coll[0]); end
    idle(); reset = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++; if (coll[m] !== 1'b0) begin errors++; $display("FAIL midreset_coll m%0d: got %b expected 0", m, coll[m]); end
    end
    test_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_clear();
    test_collision();
    test_transparent();
    test_swap_pipeline();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
